// File: rtl/flt_cmd_cfg.sv
// Flight command processor: decodes host packets into setpoints, sequences motor
// spin-up and inertial calibration, and returns an ack byte. Optional watchdog: CMD_WDOG_EN.
module flt_cmd_cfg #(
    parameter int          SPINUP_BITS = 26,
    parameter int          WDOG_BITS   = 26,
    parameter logic [7:0]  ACK         = 8'hA5,
    parameter logic [7:0]  NAK         = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        cal_done,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE, SPINUP, CAL, RESP} state_t;

    localparam logic [SPINUP_BITS-1:0] SPIN_ONE = 1;

    state_t                 state, state_nxt;
    logic [SPINUP_BITS-1:0] spin_tmr;
    logic [15:0]            ptch_q, roll_q, yaw_q;
    logic                   accept;

    // Handshake: a packet is taken on any clock edge where the FSM is IDLE and
    // cmd_rdy is high; clr_cmd_rdy follows for one cycle, and send_resp/resp is a
    // one-cycle strobe with resp stable while send_resp is high.
    assign accept    = (state == IDLE) && cmd_rdy;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            spin_tmr    <= '0;
            ptch_q      <= '0;
            roll_q      <= '0;
            yaw_q       <= '0;
            thrst       <= '0;
            motors_off  <= 1'b1;
            resp        <= ACK;
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cmd_rdy <= accept;
            send_resp   <= (state == RESP);
            if (state == SPINUP)
                spin_tmr <= spin_tmr + SPIN_ONE;
            if (state == CAL && cal_done)
                resp <= ACK;
            if (accept) begin
                resp <= ACK;
                case (cmd)
                    8'h02: ptch_q <= data;
                    8'h03: roll_q <= data;
                    8'h04: yaw_q  <= data;
                    8'h05: thrst  <= data[8:0];
                    8'h06: begin
                        motors_off <= 1'b0;
                        spin_tmr   <= '0;
                    end
                    8'h07: begin
                        ptch_q <= '0;
                        roll_q <= '0;
                        yaw_q  <= '0;
                        thrst  <= '0;
                    end
                    8'h08: motors_off <= 1'b1;
                    default: resp <= NAK;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        strt_cal     = 1'b0;
        inertial_cal = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_rdy)
                    state_nxt = (cmd == 8'h06) ? SPINUP : RESP;
            end
            SPINUP: begin
                inertial_cal = 1'b1;
                if (&spin_tmr) begin
                    strt_cal  = 1'b1;
                    state_nxt = CAL;
                end
            end
            CAL: begin
                inertial_cal = 1'b1;
                if (cal_done)
                    state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CMD_WDOG_EN
    logic [WDOG_BITS-1:0] wdog;
    logic                 wdog_trip;
    localparam logic [WDOG_BITS-1:0] WDOG_ONE = 1;

    assign wdog_trip = &wdog;

    // Saturates so a lost link keeps the attitude setpoints zeroed until the next packet.
    always_ff @(posedge clk) begin
        if (rst || accept)
            wdog <= '0;
        else if (!wdog_trip)
            wdog <= wdog + WDOG_ONE;
    end

    assign d_ptch = wdog_trip ? 16'h0000 : ptch_q;
    assign d_roll = wdog_trip ? 16'h0000 : roll_q;
    assign d_yaw  = wdog_trip ? 16'h0000 : yaw_q;
`else
    assign d_ptch = ptch_q;
    assign d_roll = roll_q;
    assign d_yaw  = yaw_q;
`endif

endmodule
